execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline.
- Consumes the ALU-input mux selects produced by the forwarding unit and resolves operands from the ID/EX values, the EX/MEM ALU result, or the MEM/WB write-back data.
- Executes the ALU operation and registers the result plus control into the EX/MEM pipeline register.
- Feeds rd_3_4 / register_write_3_4 / alu_result_3_4 back to the forwarding unit and to itself.

Parameters:
- len, 32, datapath width in bits.
- NB, $clog2(len), register-address width (5).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  1 = hold EX/MEM register contents.
- flush  in  1  1 = load a bubble into EX/MEM.
- data_a_2_3  in  len  rs value from ID/EX.
- data_b_2_3  in  len  rt value from ID/EX.
- imm_2_3  in  len  sign-extended immediate.
- shamt_2_3  in  5  shift amount field.
- rt_2_3, rd_2_3  in  NB  destination candidates.
- alu_op_2_3  in  4  ALU operation code.
- alu_src_2_3  in  1  1 = operand B is imm_2_3.
- reg_dst_2_3  in  1  1 = destination is rd_2_3, 0 = rt_2_3.
- reg_write_2_3, mem_read_2_3, mem_write_2_3, mem_to_reg_2_3  in  1 each  control passthrough.
- control_muxA, control_muxB  in  2  forwarding selects.
- write_data_4_5  in  len  MEM/WB write-back value.
- alu_result_3_4  out  len  registered ALU result.
- store_data_3_4  out  len  registered forwarded rt value for SW.
- rd_3_4  out  NB  registered destination register.
- register_write_3_4, mem_read_3_4, mem_write_3_4, mem_to_reg_3_4  out  1 each  registered control.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs = 0 immediately; they remain 0 until the first rising edge after rst_n deasserts.
- Operand A = data_a_2_3 for select 00, alu_result_3_4 for 01, write_data_4_5 for 10. Select 11 is treated as 00.
- Forwarded B (fb) uses the same select mapping, driven by control_muxB over data_b_2_3.
- Operand B = imm_2_3 when alu_src_2_3 = 1, otherwise fb.
- Store data is always fb, independent of alu_src.
- ALU ops, all results len bits, wrap-around modulo 2^len, no overflow trap:
  - 0 SLL B<<shamt; 1 SRL B>>shamt; 2 SRA arithmetic B>>>shamt.
  - 3 SLLV B<<A[4:0]; 4 SRLV; 5 SRAV.
  - 6 ADD A+B; 7 SUB A-B.
  - 8 AND; 9 OR; 10 XOR; 11 NOR.
  - 12 SLT signed A<B ? 1 : 0; 13 SLTU unsigned.
  - 14 LUI {B[15:0],16'b0}; 15 result = 0.
- Destination = rd_2_3 when reg_dst_2_3 = 1, otherwise rt_2_3.
- If the destination is 0, register_write_3_4 is forced to 0 (writes to $zero never forward).
- EX/MEM register update on each rising edge, priority flush > stall > load:
  - flush = 1: register_write, mem_read, mem_write, mem_to_reg = 0. Data fields are loaded normally (don't-care).
  - stall = 1, flush = 0: every output holds its value.
  - otherwise: load the new result and control.
- Latency: 1 cycle from ID/EX inputs to _3_4 outputs.
- Operand selection is combinational on the current alu_result_3_4, so back-to-back dependent instructions forward in consecutive cycles.
- flush and stall asserted together: flush wins and the bubble is inserted.
- rst_n asserted mid-stall or mid-flush: outputs clear immediately.

Test Plan:
- Reset: drive all inputs nonzero with rst_n=0 -> every output is 0 before and after a clk edge. Release rst_n, then ADD 3+4 -> alu_result_3_4 = 7 after one edge.
- Forward from EX/MEM: cycle 1 ADD data_a=5, data_b=6, rd=8. Cycle 2 SUB with control_muxA=01, data_a=0, data_b=1 -> alu_result_3_4 = 11 then 10.
- Forward from MEM/WB plus store: control_muxB=10, write_data_4_5=0xDEADBEEF, alu_src=1, imm=4, data_a=0x100, ADD, mem_write=1 -> alu_result_3_4 = 0x104, store_data_3_4 = 0xDEADBEEF.
- Arithmetic edges:
  - SRA shamt=4 on B=0x80000000 -> 0xF8000000.
  - SLT A=-1, B=1 -> 1; SLTU with the same operands -> 0.
  - ADD 0xFFFFFFFF+1 -> 0.
  - LUI imm=0x1234 -> 0x12340000.
- $zero write suppression: reg_write=1, reg_dst=1, rd=0 -> register_write_3_4 = 0, rd_3_4 = 0.
- Stall/flush: load ADD result 9, then stall=1 for 3 cycles with changing inputs -> outputs stay 9. Then stall=1 with flush=1 -> register_write_3_4, mem_read_3_4, mem_write_3_4, mem_to_reg_3_4 all 0.

Source files
------------

// File: rtl/execute_stage_if.sv
// ID/EX -> EX/MEM boundary of the pipeline.
// The execute stage itself is the slave.
// The driver of the ID/EX values, forwarding selects and write-back data is the master.
interface execute_stage_if #(
    parameter int len = 32,
    parameter int NB  = $clog2(len)
);
    // pipeline control
    logic            stall;
    logic            flush;

    // ID/EX operands and fields
    logic [len-1:0]  data_a_2_3;
    logic [len-1:0]  data_b_2_3;
    logic [len-1:0]  imm_2_3;
    logic [4:0]      shamt_2_3;
    logic [NB-1:0]   rt_2_3;
    logic [NB-1:0]   rd_2_3;

    // ID/EX control
    logic [3:0]      alu_op_2_3;
    logic            alu_src_2_3;
    logic            reg_dst_2_3;
    logic            reg_write_2_3;
    logic            mem_read_2_3;
    logic            mem_write_2_3;
    logic            mem_to_reg_2_3;

    // forwarding selects and MEM/WB value
    logic [1:0]      control_muxA;
    logic [1:0]      control_muxB;
    logic [len-1:0]  write_data_4_5;

    // EX/MEM register outputs
    logic [len-1:0]  alu_result_3_4;
    logic [len-1:0]  store_data_3_4;
    logic [NB-1:0]   rd_3_4;
    logic            register_write_3_4;
    logic            mem_read_3_4;
    logic            mem_write_3_4;
    logic            mem_to_reg_3_4;

    modport slave (
        input  stall, flush,
        input  data_a_2_3, data_b_2_3, imm_2_3, shamt_2_3, rt_2_3, rd_2_3,
        input  alu_op_2_3, alu_src_2_3, reg_dst_2_3,
        input  reg_write_2_3, mem_read_2_3, mem_write_2_3, mem_to_reg_2_3,
        input  control_muxA, control_muxB, write_data_4_5,
        output alu_result_3_4, store_data_3_4, rd_3_4,
        output register_write_3_4, mem_read_3_4, mem_write_3_4, mem_to_reg_3_4
    );

    modport master (
        output stall, flush,
        output data_a_2_3, data_b_2_3, imm_2_3, shamt_2_3, rt_2_3, rd_2_3,
        output alu_op_2_3, alu_src_2_3, reg_dst_2_3,
        output reg_write_2_3, mem_read_2_3, mem_write_2_3, mem_to_reg_2_3,
        output control_muxA, control_muxB, write_data_4_5,
        input  alu_result_3_4, store_data_3_4, rd_3_4,
        input  register_write_3_4, mem_read_3_4, mem_write_3_4, mem_to_reg_3_4
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage MIPS pipeline.
// It resolves the forwarded operands and runs the ALU.
// The result, store data, destination and memory/write-back control go into the EX/MEM register.
// The registered ALU result loops back into the operand muxes.
// That lets a dependent instruction in the very next cycle pick it up.
module execute_stage #(
    parameter int len = 32,
    parameter int NB  = $clog2(len)
) (
    input  logic              clk,
    input  logic              rst_n,
    execute_stage_if.slave    ex
);

    localparam logic [1:0] SEL_ID_EX  = 2'b00;
    localparam logic [1:0] SEL_EX_MEM = 2'b01;
    localparam logic [1:0] SEL_MEM_WB = 2'b10;

    localparam logic [3:0] OP_SLL  = 4'd0;
    localparam logic [3:0] OP_SRL  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd2;
    localparam logic [3:0] OP_SLLV = 4'd3;
    localparam logic [3:0] OP_SRLV = 4'd4;
    localparam logic [3:0] OP_SRAV = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NOR  = 4'd11;
    localparam logic [3:0] OP_SLT  = 4'd12;
    localparam logic [3:0] OP_SLTU = 4'd13;
    localparam logic [3:0] OP_LUI  = 4'd14;

    logic [len-1:0] operand_a;
    logic [len-1:0] forward_b;
    logic [len-1:0] operand_b;
    logic [4:0]     shift_var;
    logic [len-1:0] alu_out;
    logic [NB-1:0]  dest;
    logic           write_en;

    logic [len-1:0] alu_result_q;
    logic [len-1:0] store_data_q;
    logic [NB-1:0]  rd_q;
    logic           register_write_q;
    logic           mem_read_q;
    logic           mem_write_q;
    logic           mem_to_reg_q;

    // Operand A forwarding; the unused select 11 falls back to the ID/EX value
    always_comb begin
        operand_a = ex.data_a_2_3;
        unique case (ex.control_muxA)
            SEL_EX_MEM: operand_a = alu_result_q;
            SEL_MEM_WB: operand_a = ex.write_data_4_5;
            default:    operand_a = ex.data_a_2_3;
        endcase
    end

    // rt forwarding; this value is also the store data, whatever alu_src says
    always_comb begin
        forward_b = ex.data_b_2_3;
        unique case (ex.control_muxB)
            SEL_EX_MEM: forward_b = alu_result_q;
            SEL_MEM_WB: forward_b = ex.write_data_4_5;
            default:    forward_b = ex.data_b_2_3;
        endcase
    end

    assign operand_b = ex.alu_src_2_3 ? ex.imm_2_3 : forward_b;
    assign shift_var = operand_a[4:0];

    // ALU; all arithmetic wraps modulo 2^len, opcode 15 yields zero
    always_comb begin
        alu_out = '0;
        unique case (ex.alu_op_2_3)
            OP_SLL:  alu_out = operand_b << ex.shamt_2_3;
            OP_SRL:  alu_out = operand_b >> ex.shamt_2_3;
            OP_SRA:  alu_out = $signed(operand_b) >>> ex.shamt_2_3;
            OP_SLLV: alu_out = operand_b << shift_var;
            OP_SRLV: alu_out = operand_b >> shift_var;
            OP_SRAV: alu_out = $signed(operand_b) >>> shift_var;
            OP_ADD:  alu_out = operand_a + operand_b;
            OP_SUB:  alu_out = operand_a - operand_b;
            OP_AND:  alu_out = operand_a & operand_b;
            OP_OR:   alu_out = operand_a | operand_b;
            OP_XOR:  alu_out = operand_a ^ operand_b;
            OP_NOR:  alu_out = ~(operand_a | operand_b);
            OP_SLT:  alu_out = {{(len-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            OP_SLTU: alu_out = {{(len-1){1'b0}}, (operand_a < operand_b)};
            OP_LUI:  alu_out = {operand_b[15:0], {(len-16){1'b0}}};
            default: alu_out = '0;
        endcase
    end

    // Destination select; a write to $zero must never be seen by forwarding
    always_comb begin
        dest     = ex.reg_dst_2_3 ? ex.rd_2_3 : ex.rt_2_3;
        write_en = ex.reg_write_2_3 && (dest != '0);
    end

    // EX/MEM data fields: loaded on flush as well, since a bubble's data is don't-care
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
        end else if (ex.flush || !ex.stall) begin
            alu_result_q <= alu_out;
            store_data_q <= forward_b;
            rd_q         <= dest;
        end
    end

    // EX/MEM control fields: flush beats stall and inserts a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            register_write_q <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_to_reg_q     <= 1'b0;
        end else if (ex.flush) begin
            register_write_q <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_to_reg_q     <= 1'b0;
        end else if (!ex.stall) begin
            register_write_q <= write_en;
            mem_read_q       <= ex.mem_read_2_3;
            mem_write_q      <= ex.mem_write_2_3;
            mem_to_reg_q     <= ex.mem_to_reg_2_3;
        end
    end

    assign ex.alu_result_3_4     = alu_result_q;
    assign ex.store_data_3_4     = store_data_q;
    assign ex.rd_3_4             = rd_q;
    assign ex.register_write_3_4 = register_write_q;
    assign ex.mem_read_3_4       = mem_read_q;
    assign ex.mem_write_3_4      = mem_write_q;
    assign ex.mem_to_reg_3_4     = mem_to_reg_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage.
// A reference model tracks the EX/MEM contents from the instruction-level rules.
// It is compared against the DUT on every falling edge.
// Directed steps additionally pin hand-computed literal results.
module tb_execute_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    execute_stage_if #(.len(32)) bus ();

    execute_stage #(.len(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference EX/MEM contents
    logic [31:0] m_alu, m_store;
    logic [4:0]  m_rd;
    logic        m_rw, m_mr, m_mw, m_mtr;

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] id_val,
                                         input logic [31:0] exmem, input logic [31:0] memwb);
        if (sel == 2'd1) return exmem;
        if (sel == 2'd2) return memwb;
        return id_val;
    endfunction

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                            input logic [31:0] b, input int sh, input int vsh);
        longint sa, sb;
        logic [63:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0:  wide = {32'd0, b} * (64'd1 << sh);
            1:  wide = {32'd0, b} / (64'd1 << sh);
            2:  wide = 64'(sb >>> sh);
            3:  wide = {32'd0, b} * (64'd1 << vsh);
            4:  wide = {32'd0, b} / (64'd1 << vsh);
            5:  wide = 64'(sb >>> vsh);
            6:  wide = {32'd0, a} + {32'd0, b};
            7:  wide = {32'd0, a} - {32'd0, b};
            8:  wide = {32'd0, a & b};
            9:  wide = {32'd0, a | b};
            10: wide = {32'd0, a ^ b};
            11: wide = {32'd0, ~(a | b)};
            12: wide = (sa < sb) ? 64'd1 : 64'd0;
            13: wide = (a < b) ? 64'd1 : 64'd0;
            14: wide = {32'd0, b[15:0], 16'd0};
            default: wide = 64'd0;
        endcase
        return wide[31:0];
    endfunction

    // Model update: same timing contract as the EX/MEM register
    always @(posedge clk or negedge rst_n) begin
        logic [31:0] a, fb, b;
        logic [4:0]  d;
        if (!rst_n) begin
            m_alu = 0; m_store = 0; m_rd = 0;
            m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0;
        end else if (bus.flush || !bus.stall) begin
            a  = pick(bus.control_muxA, bus.data_a_2_3, m_alu, bus.write_data_4_5);
            fb = pick(bus.control_muxB, bus.data_b_2_3, m_alu, bus.write_data_4_5);
            b  = bus.alu_src_2_3 ? bus.imm_2_3 : fb;
            d  = bus.reg_dst_2_3 ? bus.rd_2_3 : bus.rt_2_3;
            m_alu   = ref_alu(int'(bus.alu_op_2_3), a, b, int'(bus.shamt_2_3), int'(a[4:0]));
            m_store = fb;
            m_rd    = d;
            if (bus.flush) begin
                m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0;
            end else begin
                m_rw  = bus.reg_write_2_3 && (d != 5'd0);
                m_mr  = bus.mem_read_2_3;
                m_mw  = bus.mem_write_2_3;
                m_mtr = bus.mem_to_reg_2_3;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("model alu_result",     bus.alu_result_3_4, m_alu);
        check("model store_data",     bus.store_data_3_4, m_store);
        check("model rd",             32'(bus.rd_3_4), 32'(m_rd));
        check("model register_write", 32'(bus.register_write_3_4), 32'(m_rw));
        check("model mem_read",       32'(bus.mem_read_3_4), 32'(m_mr));
        check("model mem_write",      32'(bus.mem_write_3_4), 32'(m_mw));
        check("model mem_to_reg",     32'(bus.mem_to_reg_3_4), 32'(m_mtr));
    end

    task automatic check_all_zero(input string name);
        check({name, " alu"},   bus.alu_result_3_4, 32'd0);
        check({name, " store"}, bus.store_data_3_4, 32'd0);
        check({name, " rd"},    32'(bus.rd_3_4), 32'd0);
        check({name, " ctrl"},  32'({bus.register_write_3_4, bus.mem_read_3_4,
                                     bus.mem_write_3_4, bus.mem_to_reg_3_4}), 32'd0);
    endtask

    task automatic nop();
        bus.stall = 0; bus.flush = 0;
        bus.data_a_2_3 = 0; bus.data_b_2_3 = 0; bus.imm_2_3 = 0; bus.shamt_2_3 = 0;
        bus.rt_2_3 = 0; bus.rd_2_3 = 0; bus.alu_op_2_3 = 4'd15; bus.alu_src_2_3 = 0;
        bus.reg_dst_2_3 = 0; bus.reg_write_2_3 = 0; bus.mem_read_2_3 = 0;
        bus.mem_write_2_3 = 0; bus.mem_to_reg_2_3 = 0;
        bus.control_muxA = 0; bus.control_muxB = 0; bus.write_data_4_5 = 0;
    endtask

    // Inputs change 2 time units after the rising edge, well clear of both edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic alu_rr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        nop();
        bus.alu_op_2_3 = op; bus.data_a_2_3 = a; bus.data_b_2_3 = b;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 0;
        // everything nonzero while in reset
        bus.stall = 1; bus.flush = 1;
        bus.data_a_2_3 = 32'hAAAA5555; bus.data_b_2_3 = 32'h12345678; bus.imm_2_3 = 32'h0F0F0F0F;
        bus.shamt_2_3 = 5'd3; bus.rt_2_3 = 5'd7; bus.rd_2_3 = 5'd9; bus.alu_op_2_3 = 4'd6;
        bus.alu_src_2_3 = 1; bus.reg_dst_2_3 = 1; bus.reg_write_2_3 = 1; bus.mem_read_2_3 = 1;
        bus.mem_write_2_3 = 1; bus.mem_to_reg_2_3 = 1; bus.control_muxA = 2'd1;
        bus.control_muxB = 2'd2; bus.write_data_4_5 = 32'hCAFEF00D;
        #1;
        check_all_zero("reset before edge");
        tick();
        check_all_zero("reset after edge");

        rst_n = 1;
        alu_rr(4'd6, 32'd3, 32'd4);
        tick();
        check("add 3+4", bus.alu_result_3_4, 32'd7);

        // forward from EX/MEM
        alu_rr(4'd6, 32'd5, 32'd6);
        bus.rd_2_3 = 5'd8; bus.reg_dst_2_3 = 1; bus.reg_write_2_3 = 1;
        tick();
        check("fwd add 5+6", bus.alu_result_3_4, 32'd11);
        check("fwd rd", 32'(bus.rd_3_4), 32'd8);
        alu_rr(4'd7, 32'd0, 32'd1);
        bus.control_muxA = 2'd1;
        tick();
        check("fwd sub 11-1", bus.alu_result_3_4, 32'd10);

        // forward from MEM/WB plus store
        nop();
        bus.control_muxB = 2'd2; bus.write_data_4_5 = 32'hDEADBEEF; bus.alu_src_2_3 = 1;
        bus.imm_2_3 = 32'd4; bus.data_a_2_3 = 32'h100; bus.alu_op_2_3 = 4'd6;
        bus.mem_write_2_3 = 1;
        tick();
        check("sw addr", bus.alu_result_3_4, 32'h104);
        check("sw data", bus.store_data_3_4, 32'hDEADBEEF);
        check("sw mem_write", 32'(bus.mem_write_3_4), 32'd1);

        // arithmetic edges
        alu_rr(4'd2, 32'd0, 32'h80000000); bus.shamt_2_3 = 5'd4;
        tick(); check("sra", bus.alu_result_3_4, 32'hF8000000);
        alu_rr(4'd12, 32'hFFFFFFFF, 32'd1);
        tick(); check("slt", bus.alu_result_3_4, 32'd1);
        alu_rr(4'd13, 32'hFFFFFFFF, 32'd1);
        tick(); check("sltu", bus.alu_result_3_4, 32'd0);
        alu_rr(4'd6, 32'hFFFFFFFF, 32'd1);
        tick(); check("add wrap", bus.alu_result_3_4, 32'd0);
        nop(); bus.alu_op_2_3 = 4'd14; bus.alu_src_2_3 = 1; bus.imm_2_3 = 32'h1234;
        tick(); check("lui", bus.alu_result_3_4, 32'h12340000);
        alu_rr(4'd3, 32'h00000024, 32'h00000003);
        tick(); check("sllv", bus.alu_result_3_4, 32'h00000030);
        alu_rr(4'd5, 32'd8, 32'h80000000);
        tick(); check("srav", bus.alu_result_3_4, 32'hFF800000);
        alu_rr(4'd11, 32'h0000FFFF, 32'h00FF0000);
        tick(); check("nor", bus.alu_result_3_4, 32'hFF000000);
        alu_rr(4'd10, 32'hF0F0F0F0, 32'hFFFF0000); bus.control_muxA = 2'd3;
        tick(); check("xor sel11", bus.alu_result_3_4, 32'h0F0FF0F0);
        alu_rr(4'd15, 32'd5, 32'd6);
        tick(); check("op15", bus.alu_result_3_4, 32'd0);

        // $zero suppression, and rt selection with a nonzero target
        alu_rr(4'd6, 32'd1, 32'd1);
        bus.reg_write_2_3 = 1; bus.reg_dst_2_3 = 1; bus.rd_2_3 = 5'd0; bus.rt_2_3 = 5'd4;
        tick();
        check("zero regwrite", 32'(bus.register_write_3_4), 32'd0);
        check("zero rd", 32'(bus.rd_3_4), 32'd0);
        bus.reg_dst_2_3 = 0;
        tick();
        check("rt regwrite", 32'(bus.register_write_3_4), 32'd1);
        check("rt rd", 32'(bus.rd_3_4), 32'd4);

        // stall then stall+flush
        alu_rr(4'd6, 32'd4, 32'd5);
        bus.reg_write_2_3 = 1; bus.mem_read_2_3 = 1; bus.mem_to_reg_2_3 = 1;
        bus.mem_write_2_3 = 1; bus.rd_2_3 = 5'd3; bus.reg_dst_2_3 = 1;
        tick();
        check("pre-stall", bus.alu_result_3_4, 32'd9);
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1;
            bus.data_a_2_3 = 32'(100 + i); bus.alu_op_2_3 = 4'(7 + i);
            bus.rd_2_3 = 5'(10 + i); bus.mem_read_2_3 = i[0];
            tick();
            check("stall hold alu", bus.alu_result_3_4, 32'd9);
            check("stall hold rd", 32'(bus.rd_3_4), 32'd3);
            check("stall hold ctrl", 32'({bus.register_write_3_4, bus.mem_read_3_4,
                                          bus.mem_write_3_4, bus.mem_to_reg_3_4}), 32'hF);
        end
        bus.stall = 1; bus.flush = 1;
        tick();
        check("flush ctrl", 32'({bus.register_write_3_4, bus.mem_read_3_4,
                                 bus.mem_write_3_4, bus.mem_to_reg_3_4}), 32'd0);

        // reset asserted mid-stall clears at once
        alu_rr(4'd6, 32'd20, 32'd22); bus.reg_write_2_3 = 1; bus.rd_2_3 = 5'd6; bus.reg_dst_2_3 = 1;
        tick();
        check("pre-reset", bus.alu_result_3_4, 32'd42);
        bus.stall = 1;
        #1 rst_n = 0;
        #1;
        check_all_zero("async reset");
        tick();
        rst_n = 1;
        nop();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
